cohort_dbg_reader: RTL and testbench

- Consumer end of the cohort debug-register interface.
- Takes the RegNum x 32-bit debug vector that a cohort unit drives and captures it atomically into a shadow register file.
- Serves the captured values through two paths:
  - a single-beat valid/ready read port (addressed reads);
  - a streaming dump mode that emits every register in order.
- Sits in the tile next to the cohort engine and feeds the tile's debug/CSR read path.

---
 rtl/cohort_dbg_reader_if.sv | 33 +++
 rtl/cohort_dbg_reader.sv | 151 +++++++++++++++
 tb/tb_cohort_dbg_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cohort_dbg_reader_if.sv
// +----------------------------------------------------------------------------+
// | cohort_dbg_reader_if                                                       |
// | Read-request and response channels of the cohort debug-register reader.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cohort_dbg_reader_if #(
  parameter int ADDR_W = 1
);
  logic              rd_req_valid_i;
  logic              rd_req_ready_o;
  logic [ADDR_W-1:0] rd_req_addr_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_data_o;
  logic [ADDR_W-1:0] rsp_idx_o;
  logic              rsp_err_o;
  logic              rsp_last_o;

  // Signal suffixes are named from the reader's point of view.
  modport master (
    output rd_req_valid_i, rd_req_addr_i, rsp_ready_i,
    input  rd_req_ready_o, rsp_valid_o, rsp_data_o, rsp_idx_o, rsp_err_o, rsp_last_o
  );

  modport slave (
    input  rd_req_valid_i, rd_req_addr_i, rsp_ready_i,
    output rd_req_ready_o, rsp_valid_o, rsp_data_o, rsp_idx_o, rsp_err_o, rsp_last_o
  );
endinterface

`default_nettype wire

// File: rtl/cohort_dbg_reader.sv
// +----------------------------------------------------------------------------+
// | cohort_dbg_reader                                                          |
// | Snapshots the cohort debug vector and serves it by addressed reads or a    |
// | streaming dump. COHORT_DBG_RD_SNAP_CNT_EN maps addr==REG_NUM to snap count.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cohort_dbg_reader #(
  parameter int REG_NUM = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_NUM*32-1:0]  dbg_data_i,
  input  logic                   snap_i,
  input  logic                   dump_i,
  output logic                   busy_o,
  output logic [31:0]            snap_cnt_o,
  cohort_dbg_reader_if.slave     bus
);

  localparam int ADDR_W = ($clog2(REG_NUM + 1) < 1) ? 1 : $clog2(REG_NUM + 1);
  localparam logic [ADDR_W-1:0] c_reg_num = ADDR_W'(REG_NUM);
  localparam logic [ADDR_W-1:0] c_last    = ADDR_W'(REG_NUM - 1);
  localparam logic              c_single  = (REG_NUM == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DUMP = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_shadow [REG_NUM];
  logic [31:0]       r_snap_cnt;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [ADDR_W-1:0] r_rsp_idx;
  logic              r_rsp_err;
  logic              r_rsp_last;

  logic [ADDR_W-1:0] w_idx_nxt;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_nxt_word;
  logic [31:0]       w_rd_data;
  logic              w_rd_err;
  logic              w_capture;

  assign w_idx_nxt = r_rsp_idx + ADDR_W'(1);

  // A dump start is itself a capture; explicit snaps are dropped while dumping.
  assign w_capture = (r_state != DUMP) && (snap_i || ((r_state == IDLE) && dump_i));

  always_comb begin
    w_rd_word  = '0;
    w_nxt_word = '0;
    for (int k = 0; k < REG_NUM; k++) begin
      if (bus.rd_req_addr_i == ADDR_W'(k)) w_rd_word  = r_shadow[k];
      if (w_idx_nxt == ADDR_W'(k))         w_nxt_word = r_shadow[k];
    end
  end

  always_comb begin
    w_rd_data = w_rd_word;
    w_rd_err  = 1'b0;
    if (bus.rd_req_addr_i >= c_reg_num) begin
      w_rd_data = '0;
      w_rd_err  = 1'b1;
    end
`ifdef COHORT_DBG_RD_SNAP_CNT_EN
    if (bus.rd_req_addr_i == c_reg_num) begin
      w_rd_data = r_snap_cnt;
      w_rd_err  = 1'b0;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_snap_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_idx   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
      for (int k = 0; k < REG_NUM; k++) r_shadow[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dump_i) begin
            // Beat 0 comes straight from the live bus, matching the capture on this edge.
            r_state     <= DUMP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= dbg_data_i[31:0];
            r_rsp_idx   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= c_single;
          end else if (bus.rd_req_valid_i) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_idx   <= bus.rd_req_addr_i;
            r_rsp_err   <= w_rd_err;
            r_rsp_last  <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        DUMP: begin
          if (bus.rsp_ready_i) begin
            if (r_rsp_idx == c_last) begin
              r_state     <= IDLE;
              r_rsp_valid <= 1'b0;
            end else begin
              r_rsp_idx  <= w_idx_nxt;
              r_rsp_data <= w_nxt_word;
              r_rsp_last <= (w_idx_nxt == c_last);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase

      if (w_capture) begin
        for (int k = 0; k < REG_NUM; k++) r_shadow[k] <= dbg_data_i[32*k +: 32];
        r_snap_cnt <= r_snap_cnt + 32'd1;
      end
    end
  end

  assign bus.rd_req_ready_o = (r_state == IDLE) && !dump_i;
  assign bus.rsp_valid_o    = r_rsp_valid;
  assign bus.rsp_data_o     = r_rsp_data;
  assign bus.rsp_idx_o      = r_rsp_idx;
  assign bus.rsp_err_o      = r_rsp_err;
  assign bus.rsp_last_o     = r_rsp_last;
  assign busy_o             = (r_state != IDLE);
  assign snap_cnt_o         = r_snap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cohort_dbg_reader.sv
// +----------------------------------------------------------------------------+
// | tb_cohort_dbg_reader                                                       |
// | Randomized bench for cohort_dbg_reader against a transaction-level model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cohort_dbg_reader;

  localparam int c_reg_num = 4;
  localparam int c_addr_w  = $clog2(c_reg_num + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic [c_reg_num*32-1:0] dbg_data;
  logic                    snap;
  logic                    dump;
  logic                    busy;
  logic [31:0]             snap_cnt;

  cohort_dbg_reader_if #(.ADDR_W(c_addr_w)) bus ();

  cohort_dbg_reader #(.REG_NUM(c_reg_num)) dut (
    .clk        (clk),
    .rst        (rst),
    .dbg_data_i (dbg_data),
    .snap_i     (snap),
    .dump_i     (dump),
    .busy_o     (busy),
    .snap_cnt_o (snap_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the live bus shows, what the last capture saw, how many captures.
  logic [31:0] m_live   [c_reg_num];
  logic [31:0] m_shadow [c_reg_num];
  logic [31:0] m_cnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_live();
    for (int k = 0; k < c_reg_num; k++) dbg_data[32*k +: 32] = m_live[k];
  endtask

  task automatic capture_model();
    for (int k = 0; k < c_reg_num; k++) m_shadow[k] = m_live[k];
    m_cnt = m_cnt + 32'd1;
  endtask

  function automatic logic [32:0] exp_read(input int addr);
    if (addr < c_reg_num) return {1'b0, m_shadow[addr]};
`ifdef COHORT_DBG_RD_SNAP_CNT_EN
    if (addr == c_reg_num) return {1'b0, m_cnt};
`endif
    return {1'b1, 32'h0};
  endfunction

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    capture_model();
    chk("snap_cnt", snap_cnt, m_cnt);
  endtask

  task automatic do_read(input int addr, input bit with_snap, input bit noisy);
    logic [32:0] e;
    int          stalls;
    chk("rd_ready_idle", 32'(bus.rd_req_ready_o), 32'd1);
    e = exp_read(addr);
    bus.rd_req_valid_i = 1'b1;
    bus.rd_req_addr_i  = c_addr_w'(addr);
    snap               = with_snap;
    tick();
    bus.rd_req_valid_i = 1'b0;
    snap               = 1'b0;
    if (with_snap) capture_model();
    stalls = $urandom_range(0, 3);
    for (int s = 0; s <= stalls; s++) begin
      chk("rd_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("rd_data",  bus.rsp_data_o, e[31:0]);
      chk("rd_err",   32'(bus.rsp_err_o), 32'(e[32]));
      chk("rd_idx",   32'(bus.rsp_idx_o), 32'(addr));
      chk("rd_last",  32'(bus.rsp_last_o), 32'd1);
      bus.rsp_ready_i = (s == stalls);
      if (noisy && s != stalls) begin
        m_live[$urandom_range(0, c_reg_num - 1)] = $urandom;
        drive_live();
        snap = 1'($urandom_range(0, 1));
      end
      tick();
      if (snap) capture_model();
      snap = 1'b0;
    end
    bus.rsp_ready_i = 1'b0;
    chk("rd_done_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rd_done_busy",  32'(busy), 32'd0);
    chk("rd_snap_cnt",   snap_cnt, m_cnt);
  endtask

  task automatic do_dump(input bit with_read, input bit toggle, input bit noisy);
    int beat = 0;
    int cyc  = 0;
    bit rdy;
    dump               = 1'b1;
    bus.rd_req_valid_i = with_read;
    bus.rd_req_addr_i  = c_addr_w'($urandom_range(0, c_reg_num - 1));
    #1;
    chk("dump_blocks_rd", 32'(bus.rd_req_ready_o), 32'd0);
    tick();
    dump               = 1'b0;
    bus.rd_req_valid_i = 1'b0;
    capture_model();
    while (beat < c_reg_num && cyc < 64) begin
      chk("dump_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("dump_idx",   32'(bus.rsp_idx_o), 32'(beat));
      chk("dump_data",  bus.rsp_data_o, m_shadow[beat]);
      chk("dump_err",   32'(bus.rsp_err_o), 32'd0);
      chk("dump_last",  32'(bus.rsp_last_o), 32'(beat == c_reg_num - 1));
      chk("dump_busy",  32'(busy), 32'd1);
      rdy = toggle ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      bus.rsp_ready_i = rdy;
      if (noisy) begin
        m_live[$urandom_range(0, c_reg_num - 1)] = $urandom;
        drive_live();
      end
      snap = 1'($urandom_range(0, 1));
      tick();
      snap = 1'b0;
      if (rdy) beat++;
      cyc++;
    end
    bus.rsp_ready_i = 1'b0;
    chk("dump_beats",      32'(beat), 32'(c_reg_num));
    chk("dump_done_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("dump_done_busy",  32'(busy), 32'd0);
    chk("dump_snap_cnt",   snap_cnt, m_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    snap               = 1'b0;
    dump               = 1'b0;
    bus.rd_req_valid_i = 1'b0;
    bus.rd_req_addr_i  = '0;
    bus.rsp_ready_i    = 1'b0;
    m_cnt              = '0;
    for (int k = 0; k < c_reg_num; k++) begin
      m_live[k]   = '0;
      m_shadow[k] = '0;
    end
    drive_live();
    tick();
    tick();
    chk("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_cnt",   snap_cnt, 32'd0);
    chk("rst_ready", 32'(bus.rd_req_ready_o), 32'd1);
    rst = 1'b0;

    // Capture then read: later live changes must not leak into the shadow.
    for (int k = 0; k < c_reg_num; k++) m_live[k] = $urandom;
    m_live[2] = 32'hDEAD_BEEF;
    drive_live();
    do_snap();
    m_live[2] = 32'h0000_1234;
    drive_live();
    do_read(2, 1'b0, 1'b0);

    // Same-cycle snap and read returns the pre-capture value.
    m_live[0] = 32'hA;
    drive_live();
    do_snap();
    m_live[0] = 32'hB;
    drive_live();
    do_read(0, 1'b1, 1'b0);
    do_read(0, 1'b0, 1'b0);

    // Three captures so far: out-of-range and counter address.
    do_read(c_reg_num, 1'b0, 1'b0);
    do_read(c_reg_num + 1, 1'b0, 1'b0);

    for (int k = 0; k < c_reg_num; k++) m_live[k] = 32'h10 + 32'(k);
    drive_live();
    do_dump(1'b0, 1'b1, 1'b0);
    do_dump(1'b1, 1'b0, 1'b1);

    repeat (40) begin
      case ($urandom_range(0, 3))
        0: begin
          m_live[$urandom_range(0, c_reg_num - 1)] = $urandom;
          drive_live();
          do_snap();
        end
        1: do_read($urandom_range(0, c_reg_num + 1), 1'b0, 1'b1);
        2: begin
          m_live[$urandom_range(0, c_reg_num - 1)] = $urandom;
          drive_live();
          do_read($urandom_range(0, c_reg_num + 1), 1'b1, 1'b1);
        end
        default: do_dump(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      endcase
    end

    // Reset in the middle of a dump abandons it and clears all state.
    dump = 1'b1;
    tick();
    dump = 1'b0;
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_cnt = '0;
    for (int k = 0; k < c_reg_num; k++) m_shadow[k] = '0;
    chk("mid_rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_cnt",   snap_cnt, 32'd0);
    chk("mid_rst_ready", 32'(bus.rd_req_ready_o), 32'd1);
    do_read(1, 1'b0, 1'b0);

    // Counter wrap from all-ones.
    force dut.r_snap_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_snap_cnt;
    m_cnt = 32'hFFFF_FFFF;
    chk("wrap_preset", snap_cnt, 32'hFFFF_FFFF);
    do_snap();
    chk("wrap_zero", snap_cnt, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
